// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) column helpers for the
// byte-serial encryption core.
package aes_pkg;

    localparam int NB_BYTES = 16;
    localparam int NR       = 10;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } aes_state_e;

    // Round constant for round rc (1..10); 0 outside the round window.
    function automatic logic [7:0] rcon(input logic [3:0] rc);
        logic [7:0] r;
        case (rc)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; input/output are {row0, row1, row2, row3}.
    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, combinational. Define AES_SBOX_LUT_EN for a constant
// lookup table; otherwise the byte is inverted in GF(2^8) and affine-mapped.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

`ifdef AES_SBOX_LUT_EN

    logic [127:0] row;
    logic [127:0] row_sh;

    // Upper nibble picks a 16-byte row, lower nibble picks the byte within it.
    always_comb begin
        row = 128'h0;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = 128'h0;
        endcase
        row_sh = row << {a[3:0], 3'b000};
        s      = row_sh[127:120];
    end

`else

    import aes_pkg::*;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] t;
        acc = 8'h00;
        t   = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ t;
            t = xtime(t);
        end
        return acc;
    endfunction

    logic [7:0] p;
    logic [7:0] inv;

    // inv = a^(2+4+...+128) = a^254, which is the inverse (and maps 0 to 0).
    always_comb begin
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

`endif

endmodule

// File: rtl/aes128_byte_serial_enc.sv
// Byte-serial AES-128 encryptor: 16 load cycles, 10 round cycles, 16 output
// cycles. S-box style selected by AES_SBOX_LUT_EN (see aes_sbox).
module aes128_byte_serial_enc
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_vld
);

    localparam logic [3:0] LAST_BYTE = 4'(NB_BYTES - 1);
    localparam logic [3:0] LAST_RND  = 4'(NR);

    aes_state_e   fsm_q;
    logic [3:0]   cnt_q;
    logic [3:0]   rc_q;
    logic [127:0] key_q;
    logic [127:0] state_q;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [31:0]  key_sb;
    logic [31:0]  key_tmp;
    logic [127:0] next_key;
    logic [127:0] rnd_out;
    logic [127:0] key_shift;
    logic [127:0] pt_shift;

    // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
    for (genvar i = 0; i < NB_BYTES; i++) begin : g_sub
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = 4 * ((C + R) % 4) + R;
        aes_sbox u_sbox (
            .a(state_q[127-8*i -: 8]),
            .s(sb[127-8*i -: 8])
        );
        assign sr[127-8*i -: 8] = sb[127-8*SRC -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_ksub
        aes_sbox u_sbox (
            .a(key_q[31-8*k -: 8]),
            .s(key_sb[31-8*k -: 8])
        );
    end

    // SubWord(RotWord(w3)) ^ Rcon, then the usual running XOR across words.
    assign key_tmp               = {key_sb[23:0], key_sb[31:24]} ^ {rcon(rc_q), 24'h0};
    assign next_key[127:96]      = key_q[127:96] ^ key_tmp;
    assign next_key[95:64]       = key_q[95:64]  ^ next_key[127:96];
    assign next_key[63:32]       = key_q[63:32]  ^ next_key[95:64];
    assign next_key[31:0]        = key_q[31:0]   ^ next_key[63:32];

    assign rnd_out   = ((rc_q == LAST_RND) ? sr : mc) ^ next_key;
    assign key_shift = {key_q[119:0], key_in};
    assign pt_shift  = {state_q[119:0], d_in};

    // d_vld qualifies d_out: a byte is valid in every cycle d_vld is high,
    // there is no backpressure, and the 16 bytes of a block are contiguous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= LOAD;
            cnt_q   <= 4'd0;
            rc_q    <= 4'd0;
            key_q   <= 128'h0;
            state_q <= 128'h0;
            d_out   <= 8'h00;
            d_vld   <= 1'b0;
        end else begin
            case (fsm_q)
                LOAD: begin
                    key_q <= key_shift;
                    if (cnt_q == LAST_BYTE) begin
                        state_q <= pt_shift ^ key_shift;
                        cnt_q   <= 4'd0;
                        rc_q    <= 4'd1;
                        fsm_q   <= ROUND;
                    end else begin
                        state_q <= pt_shift;
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    key_q <= next_key;
                    if (rc_q == LAST_RND) begin
                        // Present byte 0 now and keep the rest pre-shifted.
                        state_q <= {rnd_out[119:0], 8'h00};
                        d_out   <= rnd_out[127:120];
                        d_vld   <= 1'b1;
                        rc_q    <= 4'd0;
                        cnt_q   <= 4'd0;
                        fsm_q   <= OUT;
                    end else begin
                        state_q <= rnd_out;
                        rc_q    <= rc_q + 4'd1;
                    end
                end
                OUT: begin
                    if (cnt_q == LAST_BYTE) begin
                        d_out <= 8'h00;
                        d_vld <= 1'b0;
                        cnt_q <= 4'd0;
                        fsm_q <= LOAD;
                    end else begin
                        d_out   <= state_q[127:120];
                        state_q <= {state_q[119:0], 8'h00};
                        cnt_q   <= cnt_q + 4'd1;
                    end
                end
                default: begin
                    fsm_q <= LOAD;
                    cnt_q <= 4'd0;
                    rc_q  <= 4'd0;
                    d_out <= 8'h00;
                    d_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_byte_serial_enc.sv
// Self-checking bench for aes128_byte_serial_enc: known-answer vectors,
// output timing, back-to-back blocks and asynchronous reset aborts.
module tb_aes128_byte_serial_enc;

    logic       clk;
    logic       rst;
    logic [7:0] key_in;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_vld;

    aes128_byte_serial_enc dut (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_in),
        .d_in  (d_in),
        .d_out (d_out),
        .d_vld (d_vld)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs[3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] out_buf;
    int           ocnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard: assemble 16 valid bytes, compare with the oldest expected block
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            ocnt = 0;
        end else if (d_vld) begin
            out_buf = {out_buf[119:0], d_out};
            ocnt++;
            if (ocnt == 16) begin
                ocnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_block: got %h expected none", out_buf);
                end else begin
                    check("ciphertext", out_buf, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a negedge; byte i is captured on the (i+1)th following edge.
    task automatic send_block(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
        exp_q.push_back(c);
        for (int i = 0; i < 16; i++) begin
            key_in = k[127-8*i -: 8];
            d_in   = p[127-8*i -: 8];
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // From the negedge after edge 16: d_vld low through edge 25, byte 0 after edge 26.
    task automatic check_latency(input logic [7:0] first_byte);
        logic early;
        early = 1'b0;
        for (int e = 16; e <= 25; e++) begin
            if (d_vld !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        check("vld_low_before_out", 128'(early), 128'd0);
        check("first_out_byte", {119'h0, d_vld, d_out}, {119'h0, 1'b1, first_byte});
    endtask

    logic hold_bad;

    initial begin
        rst    = 1'b1;
        key_in = 8'h00;
        d_in   = 8'h00;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{key: 128'h0,
                    pt:  128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        repeat (2) @(negedge clk);
        check("reset_outputs", {119'h0, d_vld, d_out}, 128'h0);

        for (int v = 0; v < 3; v++) begin
            do_reset();
            send_block(vecs[v].key, vecs[v].pt, vecs[v].ct);
            wait_drain();
        end

        // back-to-back: second block's byte 0 on edge 43
        do_reset();
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
        check_latency(8'h69);
        repeat (15) @(negedge clk);
        check("vld_last_byte_edge41", {127'h0, d_vld}, 128'd1);
        @(negedge clk);
        check("vld_gap_after_edge42", {119'h0, d_vld, d_out}, 128'h0);
        send_block(vecs[1].key, vecs[1].pt, vecs[1].ct);
        check_latency(8'h39);
        wait_drain();

        // reset during ROUND on edge 20
        do_reset();
        send_block(vecs[1].key, vecs[1].pt, vecs[1].ct);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("round_reset_outputs", {119'h0, d_vld, d_out}, 128'h0);
        hold_bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (d_vld !== 1'b0 || d_out !== 8'h00) hold_bad = 1'b1;
        end
        check("outputs_zero_in_reset", 128'(hold_bad), 128'd0);
        rst = 1'b0;
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
        check_latency(8'h69);
        wait_drain();

        // reset during OUT after 5 output bytes
        do_reset();
        send_block(vecs[0].key, vecs[0].pt, vecs[0].ct);
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2;
        check("out_active_before_reset", {127'h0, d_vld}, 128'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("out_reset_async_drop", {119'h0, d_vld, d_out}, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_block(vecs[2].key, vecs[2].pt, vecs[2].ct);
        check_latency(8'h66);
        wait_drain();

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
